// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: two write requesters, the register-file write port and the operand bypass path.
// The master side is the pipeline/register file. The slave side is the arbiter.
interface writeback_arbiter_if;
    logic       a_valid;
    logic [1:0] a_addr;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [1:0] b_addr;
    logic [7:0] b_data;
    logic       b_ready;
    logic       stall;
    logic       write_enable;
    logic [1:0] write_addr;
    logic [7:0] write_data;
    logic [1:0] rd_addr;
    logic [7:0] rf_rd_data;
    logic [7:0] rd_data;
    logic       prio_b;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall, rd_addr, rf_rd_data,
        input  a_ready, b_ready, write_enable, write_addr, write_data, rd_data, prio_b
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall, rd_addr, rf_rd_data,
        output a_ready, b_ready, write_enable, write_addr, write_data, rd_data, prio_b
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter: ALU (A) and load (B) writebacks share one register-file write port. A granted write appears on the port one cycle later.
// Ready is combinational and is never high without its own valid. Stall withholds all grants. An unaccepted request is not buffered.
module writeback_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    writeback_arbiter_if.slave wb
);
    logic grant_a;
    logic grant_b;

    // Contention is settled by prio_b. A lone requester always wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!wb.stall) begin
            grant_a = wb.a_valid && (!wb.b_valid || !wb.prio_b);
            grant_b = wb.b_valid && (!wb.a_valid ||  wb.prio_b);
        end
    end

    assign wb.a_ready = grant_a;
    assign wb.b_ready = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.write_enable <= 1'b0;
            wb.write_addr   <= 2'd0;
            wb.write_data   <= 8'd0;
            wb.prio_b       <= 1'b0;
        end else if (grant_a) begin
            wb.write_enable <= 1'b1;
            wb.write_addr   <= wb.a_addr;
            wb.write_data   <= wb.a_data;
            wb.prio_b       <= 1'b1;
        end else if (grant_b) begin
            wb.write_enable <= 1'b1;
            wb.write_addr   <= wb.b_addr;
            wb.write_data   <= wb.b_data;
            wb.prio_b       <= 1'b0;
        end else begin
            wb.write_enable <= 1'b0;
        end
    end

    // The register file has not yet absorbed the in-flight write, so forward it to the operand read.
    assign wb.rd_data = (wb.write_enable && (wb.write_addr == wb.rd_addr)) ? wb.write_data
                                                                           : wb.rf_rd_data;
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port a_valid  input  1  requester A (ALU writeback) holds a write.
REQ-004 SHALL have port a_addr  input  2  requester A destination register.
REQ-005 SHALL have port a_data  input  8  requester A write data.
REQ-006 SHALL have port a_ready  output  1  requester A write accepted this cycle.
REQ-007 SHALL have port b_valid  input  1  requester B (load writeback) holds a write.
REQ-008 SHALL have port b_addr  input  2  requester B destination register.
REQ-009 SHALL have port b_data  input  8  requester B write data.
REQ-010 SHALL have port b_ready  output  1  requester B write accepted this cycle.
REQ-011 SHALL have port stall  input  1  freeze: no grants while high.
REQ-012 SHALL have port write_enable  output  1  register file write strobe, registered.
REQ-013 SHALL have port write_addr  output  2  register file write address, registered.
REQ-014 SHALL have port write_data  output  8  register file write data, registered.
REQ-015 SHALL have port rd_addr  input  2  operand read address being presented to the register file.
REQ-016 SHALL have port rf_rd_data  input  8  raw register file read data for rd_addr.
REQ-017 SHALL have port rd_data  output  8  bypassed operand data.
REQ-018 SHALL have port prio_b  output  1  round-robin pointer; 1 = B favoured.

Function
REQ-019 SHALL accept a write on a requester when its valid and ready are both high at a rising edge (handshake).
REQ-020 SHALL generate ready combinationally from valid, stall and prio_b; ready never high without its own valid.
REQ-021 SHALL grant at most one requester per cycle; a_ready and b_ready never high together.
REQ-022 SHALL grant nobody while stall=1; both ready low, prio_b unchanged.
REQ-023 SHALL, with exactly one valid and stall=0, grant that requester regardless of prio_b.
REQ-024 SHALL, with both valid and stall=0, grant A if prio_b=0, else B.
REQ-025 SHALL update prio_b after any grant to point at the non-granted requester (grant A -> prio_b=1, grant B -> prio_b=0); no grant -> hold.
REQ-026 SHALL register the granted addr/data into write_addr/write_data and set write_enable=1 on the edge that completes the handshake (1-cycle latency).
REQ-027 SHALL drive write_enable=0 in any cycle following a no-grant cycle; write_addr/write_data hold last values.
REQ-028 SHALL NOT merge or reorder same-address writes: with both valid to one address, both commit in grant order, last grant wins in the register file.
REQ-029 SHALL drive rd_data=write_data when write_enable=1 and write_addr==rd_addr, else rd_data=rf_rd_data (combinational bypass of the in-flight write).
REQ-030 SHALL let a requester deasserting valid without a grant drop its request; no internal buffering of unaccepted writes.

Reset
REQ-031 SHALL on rst_n low, asynchronously, force write_enable=0, write_addr=0, write_data=0, prio_b=0.
REQ-032 SHALL discard any write registered but not yet consumed when reset asserts mid-operation; ready outputs follow REQ-020 combinationally during reset but handshakes are not captured.
REQ-033 SHALL resume arbitration on the first rising edge after rst_n deasserts, favouring A.

Verification
REQ-034 Single requester: a_valid=1, a_addr=2, a_data=0x5A, stall=0 -> a_ready=1 same cycle; next cycle write_enable=1, write_addr=2, write_data=0x5A, prio_b=1.
REQ-035 Contention: both valid for 4 cycles, A addr1 data 0x11, B addr3 data 0x33, prio_b=0 -> grants A,B,A,B; write_enable high 4 consecutive cycles with alternating addr 1,3,1,3.
REQ-036 Stall: both valid, stall=1 for 3 cycles -> no ready, write_enable=0, prio_b constant; stall drop -> grant per prio_b next cycle.
REQ-037 Bypass: write_enable=1, write_addr=0, write_data=0xC3, rd_addr=0, rf_rd_data=0x00 -> rd_data=0xC3; rd_addr=1 -> rd_data=rf_rd_data.
REQ-038 Same-address collision: A addr2 0xAA and B addr2 0xBB both valid, prio_b=0 -> write 0xAA then 0xBB to addr2 on consecutive cycles.
REQ-039 Reset mid-write: rst_n low between grant edge and consumption -> write_enable=0 immediately, prio_b=0; after release, single B request granted within one cycle.
